// File: rtl/interp_pkg.sv
// interp_pkg: shared state encodings, error-bit indices and default widths
// for the interpolator step-pulse interface.
package interp_pkg;
    localparam int W_DEF  = 16;
    localparam int FW_DEF = 32;
    localparam int ERR_MULTI = 0;
    localparam int ERR_DIR   = 1;
    localparam int ERR_OVER  = 2;
    localparam int ERR_DEV   = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/pulse_edge4.sv
// pulse_edge4: rising-edge detector for the four step pulses.
// Ports: clk_i/rst_i clock and sync reset, clr_i clears the pulse history,
// pulse_i {X_acc,X_dec,Y_acc,Y_dec}, edge_o one-cycle strobes,
// multi_o high when more than one strobe fires in a cycle.
module pulse_edge4 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic [3:0] pulse_i,
    output logic [3:0] edge_o,
    output logic       multi_o
);
    logic [3:0] hist_q, hist_d;
    assign hist_d  = clr_i ? 4'b0 : pulse_i;
    assign edge_o  = pulse_i & ~hist_q;
    // x & (x-1) clears the lowest set bit; non-zero means two or more bits set
    assign multi_o = (edge_o & (edge_o - 4'd1)) != 4'b0;
    always_ff @(posedge clk_i) begin
        if (rst_i) hist_q <= 4'b0;
        else       hist_q <= hist_d;
    end
endmodule

// File: rtl/step_track.sv
// step_track: decodes interpolator step pulses, tracks signed position, step
// count and line deviation F = Y*Xe - X*Ye, and flags protocol/geometry errors.
// Ports: pulse_clk/sys_rstH clock and sync reset, startH latches Xe/Ye and
// clears tracking, X_acc/X_dec/Y_acc/Y_dec step pulses, draw_overH end of line;
// X_pos/Y_pos/step_cnt/dev/max_dev tracking outputs, errH sticky error flags,
// busyH/doneH state, matchH end-point match valid in DONE.
module step_track
    import interp_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int FW = FW_DEF
) (
    input  logic                 pulse_clk,
    input  logic                 sys_rstH,
    input  logic                 startH,
    input  logic signed [W-1:0]  Xe,
    input  logic signed [W-1:0]  Ye,
    input  logic                 X_acc,
    input  logic                 X_dec,
    input  logic                 Y_acc,
    input  logic                 Y_dec,
    input  logic                 draw_overH,
    output logic signed [W-1:0]  X_pos,
    output logic signed [W-1:0]  Y_pos,
    output logic [W:0]           step_cnt,
    output logic signed [FW-1:0] dev,
    output logic [FW-1:0]        max_dev,
    output logic [3:0]           errH,
    output logic                 busyH,
    output logic                 doneH,
    output logic                 matchH
);
    state_t state_q, state_d;
    logic signed [W-1:0] xt_q, xt_d, yt_q, yt_d, x_q, x_d, y_q, y_d, x_n, y_n;
    logic [W:0] cnt_q, cnt_d;
    logic signed [FW-1:0] f_q, f_d, f_n, xt_f, yt_f;
    logic [FW-1:0] mx_q, mx_d, af_n;
    logic [3:0] err_q, err_d;
    logic match_q, match_d, draw_q;
    logic [3:0] edges;
    logic multi, xp, xm, yp, ym;
    logic signed [W:0] xs_n, ys_n, xts, yts;
    logic [W:0] ax_n, ay_n, axt, ayt, mt;

    pulse_edge4 u_edge (
        .clk_i   (pulse_clk),
        .rst_i   (sys_rstH),
        .clr_i   (startH),
        .pulse_i ({X_acc, X_dec, Y_acc, Y_dec}),
        .edge_o  (edges),
        .multi_o (multi)
    );

    assign {xp, xm, yp, ym} = edges;
    assign xt_f = FW'(xt_q);
    assign yt_f = FW'(yt_q);
    assign x_n  = xp ? x_q + W'(1) : xm ? x_q - W'(1) : x_q;
    assign y_n  = yp ? y_q + W'(1) : ym ? y_q - W'(1) : y_q;
    assign f_n  = xp ? f_q - yt_f : xm ? f_q + yt_f : yp ? f_q + xt_f : ym ? f_q - xt_f : f_q;
    // magnitudes use one extra bit so the most negative value has a true abs
    assign xs_n = {x_n[W-1], x_n};
    assign ys_n = {y_n[W-1], y_n};
    assign xts  = {xt_q[W-1], xt_q};
    assign yts  = {yt_q[W-1], yt_q};
    assign ax_n = xs_n[W] ? -xs_n : xs_n;
    assign ay_n = ys_n[W] ? -ys_n : ys_n;
    assign axt  = xts[W] ? -xts : xts;
    assign ayt  = yts[W] ? -yts : yts;
    assign mt   = axt > ayt ? axt : ayt;
    assign af_n = f_n[FW-1] ? -f_n : f_n;

    always_comb begin
        state_d = state_q;
        xt_d    = xt_q;
        yt_d    = yt_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        mx_d    = mx_q;
        err_d   = err_q;
        match_d = match_q;
        if (startH) begin
            state_d = TRACK;
            xt_d    = Xe;
            yt_d    = Ye;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            f_d     = '0;
            mx_d    = '0;
            err_d   = '0;
            match_d = 1'b0;
        end else if (state_q == TRACK) begin
            if (multi) begin
                err_d[ERR_MULTI] = 1'b1;
            end else if (edges != 4'b0) begin
                x_d   = x_n;
                y_d   = y_n;
                cnt_d = &cnt_q ? cnt_q : cnt_q + (W+1)'(1);
                f_d   = f_n;
                mx_d  = af_n > mx_q ? af_n : mx_q;
                // a zero target has no legal direction, so any step on it errs
                if ((xp && (xt_q[W-1] || xt_q == '0)) || (xm && !xt_q[W-1]) ||
                    (yp && (yt_q[W-1] || yt_q == '0)) || (ym && !yt_q[W-1]))
                    err_d[ERR_DIR] = 1'b1;
                if (ax_n > axt || ay_n > ayt) err_d[ERR_OVER] = 1'b1;
                if (af_n > FW'(mt)) err_d[ERR_DEV] = 1'b1;
            end
            if (draw_overH && !draw_q) begin
                state_d = DONE;
                match_d = (x_d == xt_q) && (y_d == yt_q) && (err_d == 4'b0);
            end
        end
    end

    always_ff @(posedge pulse_clk) begin
        if (sys_rstH) begin
            state_q <= IDLE;
            xt_q    <= '0;
            yt_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            f_q     <= '0;
            mx_q    <= '0;
            err_q   <= '0;
            match_q <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xt_q    <= xt_d;
            yt_q    <= yt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            mx_q    <= mx_d;
            err_q   <= err_d;
            match_q <= match_d;
            draw_q  <= draw_overH;
        end
    end

    assign X_pos    = x_q;
    assign Y_pos    = y_q;
    assign step_cnt = cnt_q;
    assign dev      = f_q;
    assign max_dev  = mx_q;
    assign errH     = err_q;
    assign busyH    = state_q == TRACK;
    assign doneH    = state_q == DONE;
    assign matchH   = match_q;
endmodule

// File: tb/tb_step_track.sv
// tb_step_track: directed vector table plus hand sequences for step_track.
module tb_step_track;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, startH, X_acc, X_dec, Y_acc, Y_dec, draw;
    logic signed [15:0] Xe, Ye, X_pos, Y_pos;
    logic [16:0] step_cnt;
    logic signed [31:0] dev;
    logic [31:0] max_dev;
    logic [3:0] errH;
    logic busyH, doneH, matchH;
    int total = 0;
    int bad = 0;

    localparam logic [3:0] XP = 4'b1000, XM = 4'b0100, YP = 4'b0010, YM = 4'b0001, NP = 4'b0000;
    localparam logic [2:0] B = 3'b100, D = 3'b010, DM = 3'b011, I = 3'b000;

    typedef struct {
        logic st;
        logic signed [15:0] xe, ye;
        logic [3:0] p;
        logic dr;
        logic signed [15:0] x, y;
        logic [16:0] c;
        logic signed [31:0] d;
        logic [31:0] m;
        logic [3:0] e;
        logic [2:0] s;
    } vec_t;

    vec_t vq[$];

    step_track dut (
        .pulse_clk(clk), .sys_rstH(rst), .startH(startH), .Xe(Xe), .Ye(Ye),
        .X_acc(X_acc), .X_dec(X_dec), .Y_acc(Y_acc), .Y_dec(Y_dec),
        .draw_overH(draw), .X_pos(X_pos), .Y_pos(Y_pos), .step_cnt(step_cnt),
        .dev(dev), .max_dev(max_dev), .errH(errH), .busyH(busyH),
        .doneH(doneH), .matchH(matchH)
    );

    function automatic vec_t mk(logic st, int xe, int ye, logic [3:0] p, logic dr,
                                int x, int y, int c, int d, int m, logic [3:0] e, logic [2:0] s);
        vec_t v;
        v.st = st; v.xe = 16'(xe); v.ye = 16'(ye); v.p = p; v.dr = dr;
        v.x = 16'(x); v.y = 16'(y); v.c = 17'(c); v.d = d; v.m = 32'(m); v.e = e; v.s = s;
        return v;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic chk_all(input string n, input logic signed [15:0] x, input logic signed [15:0] y,
                           input logic [16:0] c, input logic signed [31:0] d, input logic [31:0] m,
                           input logic [3:0] e, input logic [2:0] s);
        chk({n, " X_pos"}, X_pos, x);
        chk({n, " Y_pos"}, Y_pos, y);
        chk({n, " step_cnt"}, step_cnt, c);
        chk({n, " dev"}, dev, d);
        chk({n, " max_dev"}, max_dev, m);
        chk({n, " errH"}, errH, e);
        chk({n, " busy/done/match"}, {busyH, doneH, matchH}, s);
    endtask

    task automatic drive(input logic st, input logic signed [15:0] xe, input logic signed [15:0] ye,
                         input logic [3:0] p, input logic dr);
        startH = st; Xe = xe; Ye = ye; {X_acc, X_dec, Y_acc, Y_dec} = p; draw = dr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'sd0, 16'sd0, NP, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 4'h0, I);

        // Xe=3 Ye=2 diagonal line
        vq.push_back(mk(1'b1, 3, 2, NP, 1'b0, 0, 0, 0, 0, 0, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, XP, 1'b0, 1, 0, 1, -2, 2, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, YP, 1'b0, 1, 1, 2, 1, 2, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, XP, 1'b0, 2, 1, 3, -1, 2, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, YP, 1'b0, 2, 2, 4, 2, 2, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, XP, 1'b0, 3, 2, 5, 0, 2, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, NP, 1'b1, 3, 2, 5, 0, 2, 4'h0, DM));
        // Xe=-4 Ye=0, exact end point
        vq.push_back(mk(1'b1, -4, 0, NP, 1'b0, 0, 0, 0, 0, 0, 4'h0, B));
        for (int k = 1; k <= 4; k++) vq.push_back(mk(1'b0, 0, 0, XM, 1'b0, -k, 0, k, 0, 0, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, NP, 1'b1, -4, 0, 4, 0, 0, 4'h0, DM));
        // same line with a fifth step: overshoot, no match
        vq.push_back(mk(1'b1, -4, 0, NP, 1'b0, 0, 0, 0, 0, 0, 4'h0, B));
        for (int k = 1; k <= 4; k++) vq.push_back(mk(1'b0, 0, 0, XM, 1'b0, -k, 0, k, 0, 0, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, XM, 1'b0, -5, 0, 5, 0, 0, 4'b0100, B));
        vq.push_back(mk(1'b0, 0, 0, NP, 1'b1, -5, 0, 5, 0, 0, 4'b0100, D));
        // simultaneous edges, then a wrong-direction step
        vq.push_back(mk(1'b1, 2, 2, NP, 1'b0, 0, 0, 0, 0, 0, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, XP | YP, 1'b0, 0, 0, 0, 0, 0, 4'b0001, B));
        vq.push_back(mk(1'b0, 0, 0, XM, 1'b0, -1, 0, 1, 2, 2, 4'b0011, B));
        // step on a zero-target axis
        vq.push_back(mk(1'b1, 0, 3, NP, 1'b0, 0, 0, 0, 0, 0, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, XP, 1'b0, 1, 0, 1, -3, 3, 4'b0110, B));
        // Xe=5 Ye=1, six Y+ steps
        vq.push_back(mk(1'b1, 5, 1, NP, 1'b0, 0, 0, 0, 0, 0, 4'h0, B));
        vq.push_back(mk(1'b0, 0, 0, YP, 1'b0, 0, 1, 1, 5, 5, 4'h0, B));
        for (int k = 2; k <= 6; k++) vq.push_back(mk(1'b0, 0, 0, YP, 1'b0, 0, k, k, 5 * k, 5 * k, 4'b1100, B));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].st, vq[i].xe, vq[i].ye, vq[i].p, vq[i].dr);
            @(negedge clk);
            drive(1'b0, vq[i].xe, vq[i].ye, NP, 1'b0);
            @(negedge clk);
            chk_all($sformatf("v%0d", i), vq[i].x, vq[i].y, vq[i].c, vq[i].d, vq[i].m, vq[i].e, vq[i].s);
        end

        // reset mid-run after three steps, then pulses without start are ignored
        @(negedge clk); drive(1'b1, 16'sd3, 16'sd2, NP, 1'b0);
        @(negedge clk); drive(1'b0, 16'sd3, 16'sd2, NP, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b0, 16'sd3, 16'sd2, (k == 1) ? YP : XP, 1'b0);
            @(negedge clk); drive(1'b0, 16'sd3, 16'sd2, NP, 1'b0);
        end
        chk("pre-reset step_cnt", step_cnt, 17'd3);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all("midreset", 0, 0, 0, 0, 0, 4'h0, I);
        drive(1'b0, 16'sd3, 16'sd2, XP, 1'b0);
        @(negedge clk); drive(1'b0, 16'sd3, 16'sd2, NP, 1'b1);
        @(negedge clk); drive(1'b0, 16'sd3, 16'sd2, NP, 1'b0);
        @(negedge clk);
        chk_all("idle pulses", 0, 0, 0, 0, 0, 4'h0, I);

        // step and draw_overH rising in the same cycle: step counts toward match
        drive(1'b1, 16'sd1, 16'sd0, NP, 1'b0);
        @(negedge clk); drive(1'b0, 16'sd1, 16'sd0, NP, 1'b0);
        @(negedge clk); drive(1'b0, 16'sd1, 16'sd0, XP, 1'b1);
        @(negedge clk); drive(1'b0, 16'sd1, 16'sd0, NP, 1'b0);
        chk_all("step+draw", 1, 0, 1, 0, 0, 4'h0, DM);

        // steps in DONE are ignored
        drive(1'b0, 16'sd1, 16'sd0, YP, 1'b0);
        @(negedge clk); drive(1'b0, 16'sd1, 16'sd0, NP, 1'b0);
        @(negedge clk);
        chk_all("done hold", 1, 0, 1, 0, 0, 4'h0, DM);

        // start from DONE coinciding with an X+ edge: edge discarded
        drive(1'b1, 16'sd1, -16'sd1, XP, 1'b0);
        @(negedge clk); drive(1'b0, 16'sd1, 16'sd0, NP, 1'b0);
        chk_all("start+edge", 0, 0, 0, 0, 0, 4'h0, B);
        @(negedge clk);
        chk_all("start+edge after", 0, 0, 0, 0, 0, 4'h0, B);

        // a level held high counts as one step; target latched at start (Ye=-1)
        drive(1'b0, 16'sd0, 16'sd0, XP, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 16'sd0, 16'sd0, NP, 1'b0);
        @(negedge clk);
        chk_all("held level", 1, 0, 1, 1, 1, 4'h0, B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
